// File: rtl/count_seq_checker.sv
// count_seq_checker: monitors the 4-bit state of the custom-sequence counter
// and checks it against the legal cycle 0-2-1-3-8-6-11-7-4-9-(0).
// A HUNT/SYNC/LOCK tracker with a flywheel tolerates isolated glitches.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   en       sample strobe; q_in is evaluated only when en=1
//   q_in     counter state under test
//   clr_err  synchronous clear of err_cnt (honoured even when en=0)
//   locked   high while the tracker is in LOCK
//   seq_idx  sequence position (0..9) of the last matched value
//   wrap     one-cycle pulse when value 9 is matched in LOCK
//   err      one-cycle pulse on an illegal or mismatched sample
//   err_cnt  saturating error count
module count_seq_checker #(
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       q_in,
  input  logic             clr_err,
  output logic             locked,
  output logic [3:0]       seq_idx,
  output logic             wrap,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  state_t           state, state_n;
  logic [3:0]       expected, expected_n;
  logic [3:0]       match_cnt, match_cnt_n;
  logic [3:0]       miss_cnt, miss_cnt_n;
  logic [3:0]       seq_idx_n;
  logic             locked_n, wrap_n, err_n;
  logic [ERR_W-1:0] err_cnt_n;
  logic             bump;

  // Value stored at a given sequence index.
  function automatic logic [3:0] seq_val(input logic [3:0] i);
    case (i)
      4'd0:    seq_val = 4'd0;
      4'd1:    seq_val = 4'd2;
      4'd2:    seq_val = 4'd1;
      4'd3:    seq_val = 4'd3;
      4'd4:    seq_val = 4'd8;
      4'd5:    seq_val = 4'd6;
      4'd6:    seq_val = 4'd11;
      4'd7:    seq_val = 4'd7;
      4'd8:    seq_val = 4'd4;
      4'd9:    seq_val = 4'd9;
      default: seq_val = 4'd0;
    endcase
  endfunction

  // Sequence index of a value; index 15 flags an illegal value.
  function automatic logic [3:0] seq_pos(input logic [3:0] v);
    case (v)
      4'd0:    seq_pos = 4'd0;
      4'd2:    seq_pos = 4'd1;
      4'd1:    seq_pos = 4'd2;
      4'd3:    seq_pos = 4'd3;
      4'd8:    seq_pos = 4'd4;
      4'd6:    seq_pos = 4'd5;
      4'd11:   seq_pos = 4'd6;
      4'd7:    seq_pos = 4'd7;
      4'd4:    seq_pos = 4'd8;
      4'd9:    seq_pos = 4'd9;
      default: seq_pos = 4'd15;
    endcase
  endfunction

  // Successor of a legal value in the cycle.
  function automatic logic [3:0] seq_next(input logic [3:0] v);
    logic [3:0] p;
    p = seq_pos(v);
    seq_next = (p == 4'd9) ? 4'd0 : seq_val(p + 4'd1);
  endfunction

  logic [3:0] q_idx;
  logic       q_legal;
  logic       q_match;

  assign q_idx   = seq_pos(q_in);
  assign q_legal = (q_idx != 4'd15);
  assign q_match = (q_in == expected);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      seq_idx   <= '0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      expected  <= expected_n;
      match_cnt <= match_cnt_n;
      miss_cnt  <= miss_cnt_n;
      locked    <= locked_n;
      seq_idx   <= seq_idx_n;
      wrap      <= wrap_n;
      err       <= err_n;
      err_cnt   <= err_cnt_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    expected_n  = expected;
    match_cnt_n = match_cnt;
    miss_cnt_n  = miss_cnt;
    seq_idx_n   = seq_idx;
    wrap_n      = 1'b0;
    bump        = 1'b0;

    if (en) begin
      case (state)
        HUNT: begin
          if (q_legal) begin
            expected_n  = seq_next(q_in);
            match_cnt_n = 4'd1;
            if (LOCK_CNT <= 1) begin
              state_n    = LOCK;
              miss_cnt_n = '0;
              seq_idx_n  = q_idx;
            end else begin
              state_n = SYNC;
            end
          end else begin
            bump = 1'b1;
          end
        end
        SYNC: begin
          if (q_match) begin
            match_cnt_n = match_cnt + 4'd1;
            expected_n  = seq_next(q_in);
            if (match_cnt_n >= 4'(LOCK_CNT)) begin
              state_n    = LOCK;
              miss_cnt_n = '0;
              seq_idx_n  = q_idx;
            end
          end else begin
            bump    = 1'b1;
            state_n = HUNT;
          end
        end
        LOCK: begin
          if (q_match) begin
            seq_idx_n  = q_idx;
            miss_cnt_n = '0;
            expected_n = seq_next(q_in);
            wrap_n     = (q_in == 4'd9);
          end else begin
            // Flywheel: advance the expectation as if the glitch were a good sample.
            bump       = 1'b1;
            miss_cnt_n = miss_cnt + 4'd1;
            expected_n = seq_next(expected);
            if (miss_cnt_n >= 4'(UNLOCK_CNT)) begin
              state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end

    locked_n = (state_n == LOCK);
    err_n    = bump;

    // Clear has priority over a same-cycle increment.
    err_cnt_n = err_cnt;
    if (clr_err) begin
      err_cnt_n = '0;
    end else if (bump && (err_cnt != '1)) begin
      err_cnt_n = err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: randomized and directed stimulus for two checker
// instances (default parameters, and LOCK_CNT=1/UNLOCK_CNT=3/ERR_W=2),
// compared every cycle against an index-based behavioural model.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] q_in;
  logic       clr_err;

  logic       locked_a, wrap_a, err_a;
  logic [3:0] seq_a;
  logic [7:0] cnt_a;
  logic       locked_b, wrap_b, err_b;
  logic [3:0] seq_b;
  logic [1:0] cnt_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  count_seq_checker dut_a (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in), .clr_err(clr_err),
    .locked(locked_a), .seq_idx(seq_a), .wrap(wrap_a), .err(err_a), .err_cnt(cnt_a)
  );

  count_seq_checker #(.LOCK_CNT(1), .UNLOCK_CNT(3), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in), .clr_err(clr_err),
    .locked(locked_b), .seq_idx(seq_b), .wrap(wrap_b), .err(err_b), .err_cnt(cnt_b)
  );

  // Behavioural model: tracks the expected position as an index into the cycle.
  int seq_tab[10]     = '{0, 2, 1, 3, 8, 6, 11, 7, 4, 9};
  int lock_need[2]    = '{3, 1};
  int unlock_need[2]  = '{2, 3};
  int cnt_max[2]      = '{255, 3};
  int mode[2]         = '{0, 0};   // 0 hunting, 1 syncing, 2 locked
  int nxt[2]          = '{0, 0};
  int run[2]          = '{0, 0};
  int miss[2]         = '{0, 0};
  int m_seq[2]        = '{0, 0};
  int m_cnt[2]        = '{0, 0};
  int m_lock[2]       = '{0, 0};
  int m_wrap[2]       = '{0, 0};
  int m_err[2]        = '{0, 0};

  function automatic int pos_of(input int v);
    for (int i = 0; i < 10; i++) if (seq_tab[i] == v) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; nxt[k] = 0; run[k] = 0; miss[k] = 0; m_seq[k] = 0;
      m_cnt[k] = 0; m_lock[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int e, input int q, input int c);
    int i;
    int bad;
    bad = 0;
    m_wrap[k] = 0;
    if (e != 0) begin
      i = pos_of(q);
      if (mode[k] == 0) begin
        if (i < 0) bad = 1;
        else begin
          nxt[k] = (i + 1) % 10;
          run[k] = 1;
          if (run[k] >= lock_need[k]) begin mode[k] = 2; miss[k] = 0; m_seq[k] = i; end
          else mode[k] = 1;
        end
      end else if (mode[k] == 1) begin
        if (i >= 0 && i == nxt[k]) begin
          run[k] = run[k] + 1;
          nxt[k] = (i + 1) % 10;
          if (run[k] >= lock_need[k]) begin mode[k] = 2; miss[k] = 0; m_seq[k] = i; end
        end else begin
          bad = 1;
          mode[k] = 0;
        end
      end else begin
        if (i >= 0 && i == nxt[k]) begin
          m_seq[k] = i;
          miss[k] = 0;
          nxt[k] = (i + 1) % 10;
          m_wrap[k] = (q == 9) ? 1 : 0;
        end else begin
          bad = 1;
          miss[k] = miss[k] + 1;
          nxt[k] = (nxt[k] + 1) % 10;
          if (miss[k] >= unlock_need[k]) mode[k] = 0;
        end
      end
    end
    if (c != 0) m_cnt[k] = 0;
    else if (bad != 0 && m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
    m_err[k]  = bad;
    m_lock[k] = (mode[k] == 2) ? 1 : 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0, int'(en), int'(q_in), int'(clr_err));
      model_step(1, int'(en), int'(q_in), int'(clr_err));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("locked_a",  32'(locked_a), 32'(m_lock[0]));
    chk("seq_idx_a", 32'(seq_a),    32'(m_seq[0]));
    chk("wrap_a",    32'(wrap_a),   32'(m_wrap[0]));
    chk("err_a",     32'(err_a),    32'(m_err[0]));
    chk("err_cnt_a", 32'(cnt_a),    32'(m_cnt[0]));
    chk("locked_b",  32'(locked_b), 32'(m_lock[1]));
    chk("seq_idx_b", 32'(seq_b),    32'(m_seq[1]));
    chk("wrap_b",    32'(wrap_b),   32'(m_wrap[1]));
    chk("err_b",     32'(err_b),    32'(m_err[1]));
    chk("err_cnt_b", 32'(cnt_b),    32'(m_cnt[1]));
  end

  task automatic apply(input logic e, input logic [3:0] q, input logic c);
    en = e; q_in = q; clr_err = c;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  int vals[8] = '{3, 8, 6, 11, 7, 4, 9, 0};
  int idxs[8] = '{3, 4, 5, 6, 7, 8, 9, 0};
  int wraps;
  logic [3:0] rq;

  initial begin
    rst = 1'b1; en = 1'b0; q_in = 4'd0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_locked",  32'(locked_a), 32'd0);
    chk("rst_err_cnt", 32'(cnt_a),    32'd0);
    chk("rst_seq_idx", 32'(seq_a),    32'd0);
    rst = 1'b0;

    // Acquire lock on 0, 2, 1.
    apply(1'b1, 4'd0, 1'b0);
    apply(1'b1, 4'd2, 1'b0);
    chk("lock_early", 32'(locked_a), 32'd0);
    apply(1'b1, 4'd1, 1'b0);
    chk("lock_locked",  32'(locked_a), 32'd1);
    chk("lock_seq_idx", 32'(seq_a),    32'd2);
    chk("lock_err",     32'(err_a),    32'd0);

    // Walk the rest of the cycle.
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 4'(vals[i]), 1'b0);
      chk("walk_seq_idx", 32'(seq_a), 32'(idxs[i]));
      wraps += int'(wrap_a);
    end
    chk("walk_wraps",   32'(wraps), 32'd1);
    chk("walk_err_cnt", 32'(cnt_a), 32'd0);

    // Flywheel over a single glitch while expecting 8.
    apply(1'b1, 4'd2, 1'b0);
    apply(1'b1, 4'd1, 1'b0);
    apply(1'b1, 4'd3, 1'b0);
    apply(1'b1, 4'd5, 1'b0);
    chk("fly_err",     32'(err_a),    32'd1);
    chk("fly_err_cnt", 32'(cnt_a),    32'd1);
    chk("fly_locked",  32'(locked_a), 32'd1);
    apply(1'b1, 4'd6, 1'b0);
    chk("fly_seq_idx", 32'(seq_a),    32'd5);
    chk("fly_err2",    32'(err_a),    32'd0);
    chk("fly_locked2", 32'(locked_a), 32'd1);

    // Two consecutive misses drop lock, then relock.
    apply(1'b1, 4'd15, 1'b0);
    chk("miss1_locked", 32'(locked_a), 32'd1);
    apply(1'b1, 4'd15, 1'b0);
    chk("miss2_locked",  32'(locked_a), 32'd0);
    chk("miss2_err_cnt", 32'(cnt_a),    32'd3);
    apply(1'b1, 4'd0, 1'b0);
    apply(1'b1, 4'd2, 1'b0);
    chk("relock_early", 32'(locked_a), 32'd0);
    apply(1'b1, 4'd1, 1'b0);
    chk("relock_locked", 32'(locked_a), 32'd1);

    // Saturation of the narrow counter, then clear beating an increment.
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (5) apply(1'b1, 4'd12, 1'b0);
    chk("sat_cnt_b", 32'(cnt_b), 32'd3);
    chk("sat_cnt_a", 32'(cnt_a), 32'd5);
    apply(1'b1, 4'd12, 1'b1);
    chk("clr_cnt_b", 32'(cnt_b), 32'd0);
    chk("clr_cnt_a", 32'(cnt_a), 32'd0);
    chk("clr_err_a", 32'(err_a), 32'd1);

    // Hold with en=0, then asynchronous reset mid-cycle.
    apply(1'b1, 4'd0, 1'b0);
    apply(1'b1, 4'd2, 1'b0);
    apply(1'b1, 4'd1, 1'b0);
    apply(1'b1, 4'd15, 1'b0);
    chk("hold_pre_cnt", 32'(cnt_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      chk("hold_locked", 32'(locked_a), 32'd1);
      chk("hold_seq",    32'(seq_a),    32'd2);
      chk("hold_cnt",    32'(cnt_a),    32'd1);
      chk("hold_err",    32'(err_a),    32'd0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_locked", 32'(locked_a), 32'd0);
    chk("arst_cnt",    32'(cnt_a),    32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Randomized traffic biased toward the expected next value.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 75) rq = 4'(seq_tab[nxt[0]]);
      else rq = 4'($urandom_range(0, 15));
      apply(($urandom_range(0, 99) < 85), rq, ($urandom_range(0, 99) < 3));
    end
    rst = 1'b0;
    apply(1'b0, 4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Downstream monitor for the custom-sequence T-flip-flop counter.
- Samples the counter's 4-bit state and checks it against the legal cycle 0-2-1-3-8-6-11-7-4-9-(0).
- Reports lock status, sequence position, cycle completion and error statistics to the rest of the lab design.
- Provides a flywheel so that a single glitch does not drop lock.

Parameters:
- LOCK_CNT, 3: consecutive in-sequence samples required to declare lock (1..15).
- UNLOCK_CNT, 2: consecutive mismatches in LOCK that force a return to HUNT (1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample strobe; q_in is evaluated only on cycles where en=1.
- q_in  input  4  counter state under test.
- clr_err  input  1  synchronous clear of err_cnt.
- locked  output  1  high while the FSM is in LOCK.
- seq_idx  output  4  position 0..9 of the last matched value in LOCK.
- wrap  output  1  one-cycle pulse when value 9 (index 9) is matched in LOCK.
- err  output  1  one-cycle pulse on any illegal or mismatched sample.
- err_cnt  output  ERR_W  saturating error count.

Behaviour:
- Sequence table (index:value): 0:0, 1:2, 2:1, 3:3, 4:8, 5:6, 6:11, 7:7, 8:4, 9:9.
  - next(v) is the value at the following index; next(9)=0.
  - Legal values are these ten. Values 5, 10, 12, 13, 14 and 15 are illegal.
- Registers: state, expected[3:0], match_cnt[3:0], miss_cnt[3:0].
  - All outputs are registered and update on the clk edge that samples q_in (one-cycle latency).
- rst=1, asynchronous, at any time including mid-LOCK:
  - state=HUNT; expected, match_cnt, miss_cnt = 0.
  - locked=0, seq_idx=0, wrap=0, err=0, err_cnt=0.
- en=0: all registers hold; wrap=0 and err=0.
- HUNT, on sample:
  - Legal q_in: expected=next(q_in), match_cnt=1; go to SYNC, or directly to LOCK if LOCK_CNT=1.
  - Illegal q_in: err=1, err_cnt increments, stay in HUNT.
- SYNC, on sample:
  - q_in==expected: match_cnt increments, expected=next(q_in). When match_cnt reaches LOCK_CNT, go to LOCK with miss_cnt=0.
  - Mismatch: err=1, err_cnt increments, go to HUNT. No reseed on that sample.
- LOCK, on sample:
  - q_in==expected: seq_idx=index(q_in), miss_cnt=0, expected=next(q_in). wrap=1 if q_in==9.
  - Mismatch: err=1, err_cnt increments, miss_cnt increments, expected=next(expected) (flywheel); seq_idx holds.
  - When miss_cnt reaches UNLOCK_CNT: go to HUNT, locked falls on that same edge.
- locked is asserted on the edge that enters LOCK.
- err_cnt:
  - Saturates at 2^ERR_W-1.
  - clr_err=1 forces 0; clear wins over a simultaneous increment.
  - clr_err is honoured even when en=0.
- Entering HUNT from LOCK does not touch seq_idx or err_cnt.

Test Plan:
- Reset, then en=1 with q_in = 0, 2, 1 on three consecutive cycles -> locked=1 after the third edge; err=0; seq_idx=2.
- Locked; drive 3, 8, 6, 11, 7, 4, 9, 0 -> seq_idx tracks 3..9 then 0; wrap pulses exactly once, on the 9 sample; err_cnt=0.
- Locked, expected=8; drive 5 then 6 -> err pulses once, err_cnt=1, locked stays 1; the 6 matches via flywheel and seq_idx=5.
- Locked; drive two consecutive wrong values (e.g. 15, 15) -> err_cnt +2, locked=0 after the second; next legal 0, 2, 1 relocks after 3 samples.
- Parameter ERR_W=2 in HUNT; drive 12 five times -> err_cnt saturates at 3. Then clr_err=1 together with an illegal sample -> err_cnt=0.
- Locked; en=0 for 4 cycles with q_in varying -> no output change. Then assert rst asynchronously mid-cycle -> locked=0 and err_cnt=0 immediately, without waiting for a clock edge.
